// File: rtl/expr_recognizer_if.sv
// Character-in / status-out bundle for expr_recognizer.
// The master modport drives characters; the slave modport reports recogniser status.
interface expr_recognizer_if #(
  parameter int MAX_DEPTH = 7,
  parameter int CNT_W     = 8
);
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  logic               in_vld;
  logic [7:0]         in_chr;
  logic               out;
  logic               err;
  logic [DEPTH_W-1:0] depth;
  logic [CNT_W-1:0]   op_cnt;

  modport master (output in_vld, in_chr, input  out, err, depth, op_cnt);
  modport slave  (input  in_vld, in_chr, output out, err, depth, op_cnt);
endinterface

// File: rtl/expr_recognizer.sv
// Streaming ASCII arithmetic-expression recogniser, one char per valid cycle.
// Parenthesis support is compiled in only when EXPR_PAREN_EN is defined.
//
// state   | meaning
// S_INIT  | nothing consumed since clr, operand required
// S_NUM   | inside an operand, dig_q digits so far
// S_OP    | after an operator or '(', operand required
// S_CLOSE | after ')'
// S_ERR   | syntax error seen, absorbing until clr
module expr_recognizer #(
  parameter int MAX_DIGITS = 4,
  parameter int MAX_DEPTH  = 7,
  parameter int CNT_W      = 8,
  parameter int ALLOW_SUB  = 0
) (
  input  logic              clk_i,
  input  logic              clr_i,
  expr_recognizer_if.slave  expr_io
);
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
  localparam int DIG_W   = $clog2(MAX_DIGITS + 1);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_NUM   = 3'd1,
    S_OP    = 3'd2,
    S_CLOSE = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [DIG_W-1:0]   dig_q, dig_d;
  logic [CNT_W-1:0]   op_q, op_d;
  logic               is_digit, is_op;
  logic               need_operand, after_operand;

  assign is_digit = (expr_io.in_chr >= 8'h30) && (expr_io.in_chr <= 8'h39);
  assign is_op    = (expr_io.in_chr == 8'h2B) || (expr_io.in_chr == 8'h2A) ||
                    ((ALLOW_SUB != 0) && (expr_io.in_chr == 8'h2D));
  assign need_operand  = (state_q == S_INIT) || (state_q == S_OP);
  assign after_operand = (state_q == S_NUM) || (state_q == S_CLOSE);

`ifdef EXPR_PAREN_EN
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               is_lpar, is_rpar;
  assign is_lpar = (expr_io.in_chr == 8'h28);
  assign is_rpar = (expr_io.in_chr == 8'h29);
`endif

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    op_d    = op_q;
`ifdef EXPR_PAREN_EN
    depth_d = depth_q;
`endif
    if (expr_io.in_vld && (state_q != S_ERR)) begin
      // Anything not explicitly legal below falls through to the error state.
      state_d = S_ERR;
      if (is_digit) begin
        if (need_operand) begin
          state_d = S_NUM;
          dig_d   = DIG_W'(1);
        end else if ((state_q == S_NUM) && (dig_q < DIG_W'(MAX_DIGITS))) begin
          state_d = S_NUM;
          dig_d   = dig_q + DIG_W'(1);
        end
      end else if (is_op) begin
        if (after_operand) begin
          state_d = S_OP;
          if (op_q != {CNT_W{1'b1}}) op_d = op_q + CNT_W'(1);
        end
      end
`ifdef EXPR_PAREN_EN
      else if (is_lpar) begin
        if (need_operand && (depth_q < DEPTH_W'(MAX_DEPTH))) begin
          state_d = S_OP;
          depth_d = depth_q + DEPTH_W'(1);
        end
      end else if (is_rpar) begin
        if (after_operand && (depth_q != '0)) begin
          state_d = S_CLOSE;
          depth_d = depth_q - DEPTH_W'(1);
        end
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q <= S_INIT;
      dig_q   <= '0;
      op_q    <= '0;
`ifdef EXPR_PAREN_EN
      depth_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      op_q    <= op_d;
`ifdef EXPR_PAREN_EN
      depth_q <= depth_d;
`endif
    end
  end

`ifdef EXPR_PAREN_EN
  assign expr_io.out   = after_operand && (depth_q == '0);
  assign expr_io.depth = depth_q;
`else
  assign expr_io.out   = after_operand;
  assign expr_io.depth = '0;
`endif
  assign expr_io.err    = (state_q == S_ERR);
  assign expr_io.op_cnt = op_q;
endmodule

// File: tb/tb_expr_recognizer.sv
// Directed, table-driven bench for expr_recognizer: one instance with ALLOW_SUB=0
// and one with ALLOW_SUB=1, both fed the same character stream.
module tb_expr_recognizer;
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  expr_recognizer_if #(.MAX_DEPTH(7), .CNT_W(8)) bus0 ();
  expr_recognizer_if #(.MAX_DEPTH(7), .CNT_W(8)) bus1 ();

  expr_recognizer #(.MAX_DIGITS(4), .MAX_DEPTH(7), .CNT_W(8), .ALLOW_SUB(0)) u_dut (
    .clk_i(clk), .clr_i(clr), .expr_io(bus0));
  expr_recognizer #(.MAX_DIGITS(4), .MAX_DEPTH(7), .CNT_W(8), .ALLOW_SUB(1)) u_dut_sub (
    .clk_i(clk), .clr_i(clr), .expr_io(bus1));

  typedef struct {
    logic       clr;
    logic       vld;
    logic [7:0] chr;
    logic       out;
    logic       err;
    int         depth;
    int         op;
    logic       out_s;
    logic       err_s;
    int         op_s;
  } vec_t;

  vec_t vecs[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic add(input logic c, input logic v, input logic [7:0] ch,
                     input logic o, input logic e, input int d, input int op,
                     input logic os, input logic es, input int ops);
    vec_t t;
    t.clr = c; t.vld = v; t.chr = ch; t.out = o; t.err = e; t.depth = d; t.op = op;
    t.out_s = os; t.err_s = es; t.op_s = ops;
    vecs.push_back(t);
  endtask

  // Same expectation for both instances.
  task automatic add2(input logic c, input logic v, input logic [7:0] ch,
                      input logic o, input logic e, input int d, input int op);
    add(c, v, ch, o, e, d, op, o, e, op);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic v, input logic [7:0] ch);
    @(negedge clk);
    clr = c;
    bus0.in_vld = v; bus0.in_chr = ch;
    bus1.in_vld = v; bus1.in_chr = ch;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1;
    bus0.in_vld = 1'b0; bus0.in_chr = 8'h00;
    bus1.in_vld = 1'b0; bus1.in_chr = 8'h00;

    // reset
    add2(1, 0, "0", 0, 0, 0, 0);
    // "1+2*3"
    add2(0, 1, "1", 1, 0, 0, 0);
    add2(0, 1, "+", 0, 0, 0, 1);
    add2(0, 1, "2", 1, 0, 0, 1);
    add2(0, 1, "*", 0, 0, 0, 2);
    add2(0, 1, "3", 1, 0, 0, 2);
    add2(1, 0, "0", 0, 0, 0, 0);
    // "12345+1": fifth digit overflows
    add2(0, 1, "1", 1, 0, 0, 0);
    add2(0, 1, "2", 1, 0, 0, 0);
    add2(0, 1, "3", 1, 0, 0, 0);
    add2(0, 1, "4", 1, 0, 0, 0);
    add2(0, 1, "5", 0, 1, 0, 0);
    add2(0, 1, "+", 0, 1, 0, 0);
    add2(0, 1, "1", 0, 1, 0, 0);
    add2(1, 0, "0", 0, 0, 0, 0);
    // "1+" bubbles "2"
    add2(0, 1, "1", 1, 0, 0, 0);
    add2(0, 1, "+", 0, 0, 0, 1);
    add2(0, 0, "9", 0, 0, 0, 1);
    add2(0, 0, "9", 0, 0, 0, 1);
    add2(0, 0, "+", 0, 0, 0, 1);
    add2(0, 1, "2", 1, 0, 0, 1);
    add2(1, 0, "0", 0, 0, 0, 0);
    // "5-1": illegal without subtraction, legal with it
    add (0, 1, "5", 1, 0, 0, 0, 1, 0, 0);
    add (0, 1, "-", 0, 1, 0, 0, 0, 0, 1);
    add (0, 1, "1", 0, 1, 0, 0, 1, 0, 1);
    add2(1, 0, "0", 0, 0, 0, 0);
    // "007*+": leading zeros fine, double operator errors, op_cnt holds
    add2(0, 1, "0", 1, 0, 0, 0);
    add2(0, 1, "0", 1, 0, 0, 0);
    add2(0, 1, "7", 1, 0, 0, 0);
    add2(0, 1, "*", 0, 0, 0, 1);
    add2(0, 1, "+", 0, 1, 0, 1);
    add2(1, 0, "0", 0, 0, 0, 0);
    // leading operator, space byte
    add2(0, 1, "+", 0, 1, 0, 0);
    add2(1, 0, "0", 0, 0, 0, 0);
    add2(0, 1, "1", 1, 0, 0, 0);
    add2(0, 1, " ", 0, 1, 0, 0);
    add2(1, 0, "0", 0, 0, 0, 0);
    // clr mid "3*" wins over in_vld
    add2(0, 1, "3", 1, 0, 0, 0);
    add2(0, 1, "*", 0, 0, 0, 1);
    add2(1, 1, "1", 0, 0, 0, 0);
    add2(0, 1, "4", 1, 0, 0, 0);
    add2(1, 0, "0", 0, 0, 0, 0);
`ifdef EXPR_PAREN_EN
    // "(1+(2))*3"
    add2(0, 1, "(", 0, 0, 1, 0);
    add2(0, 1, "1", 0, 0, 1, 0);
    add2(0, 1, "+", 0, 0, 1, 1);
    add2(0, 1, "(", 0, 0, 2, 1);
    add2(0, 1, "2", 0, 0, 2, 1);
    add2(0, 1, ")", 0, 0, 1, 1);
    add2(0, 1, ")", 1, 0, 0, 1);
    add2(0, 1, "*", 0, 0, 0, 2);
    add2(0, 1, "3", 1, 0, 0, 2);
    add2(1, 0, "0", 0, 0, 0, 0);
    // "1)" unbalanced close
    add2(0, 1, "1", 1, 0, 0, 0);
    add2(0, 1, ")", 0, 1, 0, 0);
    add2(1, 0, "0", 0, 0, 0, 0);
    // "()" empty group, depth holds at error
    add2(0, 1, "(", 0, 0, 1, 0);
    add2(0, 1, ")", 0, 1, 1, 0);
    add2(1, 0, "0", 0, 0, 0, 0);
    // "(1)2" digit after close
    add2(0, 1, "(", 0, 0, 1, 0);
    add2(0, 1, "1", 0, 0, 1, 0);
    add2(0, 1, ")", 1, 0, 0, 0);
    add2(0, 1, "2", 0, 1, 0, 0);
    add2(1, 0, "0", 0, 0, 0, 0);
`else
    // parentheses are illegal bytes in this build
    add2(0, 1, "(", 0, 1, 0, 0);
    add2(1, 0, "0", 0, 0, 0, 0);
    add2(0, 1, "1", 1, 0, 0, 0);
    add2(0, 1, ")", 0, 1, 0, 0);
    add2(1, 0, "0", 0, 0, 0, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].vld, vecs[i].chr);
      chk($sformatf("v%0d.out", i),     int'(bus0.out),    int'(vecs[i].out));
      chk($sformatf("v%0d.err", i),     int'(bus0.err),    int'(vecs[i].err));
      chk($sformatf("v%0d.depth", i),   int'(bus0.depth),  vecs[i].depth);
      chk($sformatf("v%0d.op_cnt", i),  int'(bus0.op_cnt), vecs[i].op);
      chk($sformatf("v%0d.sub_out", i), int'(bus1.out),    int'(vecs[i].out_s));
      chk($sformatf("v%0d.sub_err", i), int'(bus1.err),    int'(vecs[i].err_s));
      chk($sformatf("v%0d.sub_op", i),  int'(bus1.op_cnt), vecs[i].op_s);
    end

    // op_cnt saturation: "1" followed by 260 "+1" pairs
    drive(1, 0, "0");
    drive(0, 1, "1");
    for (int i = 1; i <= 260; i++) begin
      drive(0, 1, "+");
      drive(0, 1, "1");
      if (i == 254) chk("sat.op254", int'(bus0.op_cnt), 254);
      if (i == 255) chk("sat.op255", int'(bus0.op_cnt), 255);
    end
    chk("sat.op_final", int'(bus0.op_cnt), 255);
    chk("sat.out", int'(bus0.out), 1);
    chk("sat.err", int'(bus0.err), 0);

`ifdef EXPR_PAREN_EN
    // nesting limit: eight '(' with MAX_DEPTH=7
    drive(1, 0, "0");
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1, "(");
      chk($sformatf("nest%0d.depth", i), int'(bus0.depth), (i <= 7) ? i : 7);
      chk($sformatf("nest%0d.err", i),   int'(bus0.err),   (i <= 7) ? 0 : 1);
    end
    // ")" straight from reset
    drive(1, 0, "0");
    drive(0, 1, ")");
    chk("rpar_reset.err", int'(bus0.err), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
